// File: rtl/alu_stage_one.sv
// alu_stage_one: first half of the split ALU. Decodes the op, computes
// all non-additive results plus the low 16-bit add/sub, and registers them.
package alu_stage_one_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_BEQ  = 4'd10,
    OP_BNE  = 4'd11,
    OP_BLT  = 4'd12,
    OP_BGE  = 4'd13,
    OP_BLTU = 4'd14,
    OP_BGEU = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
    logic        add;
    logic [15:0] lo;
    logic        carry;
  } s1_s2_t;

endpackage

module alu_stage_one
  import alu_stage_one_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUOut_1,
  output logic             Branch_Enable_1,
  output logic             addition_flag,
  output logic [15:0]      last_16_bits_result,
  output logic             carry_bit
);

  alu_op_e     op;
  logic        is_sub;
  logic        is_add;
  logic [31:0] b_c;
  logic [16:0] sum_lo;
  logic [4:0]  shamt;
  logic        eq;
  logic        lt_s;
  logic        lt_u;
  logic [31:0] res;
  logic        br;
  s1_s2_t      nxt;
  s1_s2_t      q;
  logic        xfer_in;
  logic        xfer_out;

  assign op     = alu_op_e'(ALUctl);
  assign is_sub = (op == OP_SUB);
  assign is_add = (op == OP_ADD) || is_sub;
  assign shamt  = B_in[4:0];

  assign eq   = (A_in == B_in);
  assign lt_s = ($signed(A_in) < $signed(B_in));
  assign lt_u = (A_in < B_in);

  // Subtract as A + ~B + 1; stage two reuses the inverted B upper half.
  assign b_c    = is_sub ? ~B_in : B_in;
  assign sum_lo = {1'b0, A_in[15:0]}
                + {1'b0, b_c[15:0]}
                + {16'b0, is_sub};

  always_comb begin
    res = '0;
    br  = 1'b0;
    unique case (op)
      OP_ADD,
      OP_SUB:  res = '0;
      OP_AND:  res = A_in & B_in;
      OP_OR:   res = A_in | B_in;
      OP_XOR:  res = A_in ^ B_in;
      OP_SLL:  res = A_in << shamt;
      OP_SRL:  res = A_in >> shamt;
      OP_SRA:  res = $unsigned($signed(A_in) >>> shamt);
      OP_SLT:  res = {31'b0, lt_s};
      OP_SLTU: res = {31'b0, lt_u};
      OP_BEQ:  br  = eq;
      OP_BNE:  br  = !eq;
      OP_BLT:  br  = lt_s;
      OP_BGE:  br  = !lt_s;
      OP_BLTU: br  = lt_u;
      OP_BGEU: br  = !lt_u;
    endcase
  end

  always_comb begin
    nxt       = '0;
    nxt.a     = A_in;
    nxt.b     = b_c;
    nxt.res   = res;
    nxt.br    = br;
    nxt.add   = is_add;
    nxt.lo    = is_add ? sum_lo[15:0] : 16'h0;
    nxt.carry = is_add & sum_lo[16];
  end

  assign in_ready = !out_valid || out_ready;
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

  // Flush wins over any same-cycle transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer_in) begin
      out_valid <= 1'b1;
    end else if (xfer_out) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (xfer_in && !flush) begin
      q <= nxt;
    end
  end

  assign A                   = q.a;
  assign B                   = q.b;
  assign ALUOut_1            = q.res;
  assign Branch_Enable_1     = q.br;
  assign addition_flag       = q.add;
  assign last_16_bits_result = q.lo;
  assign carry_bit           = q.carry;

endmodule

// File: doc/alu_stage_one.md
# alu_stage_one

Stage 1 of the split ALU pipeline. Decodes the ALU operation, computes every non-additive result in full, computes the low 16 bits of addition/subtraction with carry-out, and registers all of it for `alu_stage_two`. Stage two completes the upper 16 bits from the registered operands and carry. A valid/ready handshake with flush sits between the decode side and the completion stage.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Only 32 is supported; the split point is fixed at bit 16.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operands and op valid this cycle
- `in_ready`  out  1  stage can accept a transfer this cycle
- `ALUctl`  in  4  operation code (see Operation)
- `A_in`, `B_in`  in  32  operands
- `flush`  in  1  discard the held result; synchronous
- `out_valid`  out  1  registered result valid
- `out_ready`  in  1  stage two / consumer accepts the result
- `A`  out  32  registered A
- `B`  out  32  registered conditioned B: `~B_in` for SUB, `B_in` otherwise
- `ALUOut_1`  out  32  registered non-additive result; 0 for ADD/SUB/branch ops
- `Branch_Enable_1`  out  1  registered branch decision; 0 for non-branch ops
- `addition_flag`  out  1  registered; 1 for ADD/SUB
- `last_16_bits_result`  out  16  registered low half of the sum
- `carry_bit`  out  1  registered carry out of bit 15

## Operation
- ALUctl encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
- ADD: compute `{carry, low} = A_in[15:0] + B_in[15:0] + 0`.
- SUB: `Bc = ~B_in`. Compute `{carry, low} = A_in[15:0] + Bc[15:0] + 1`. Output `B = Bc`. Stage two's `A[31:16]+B[31:16]+carry` then yields the correct two's-complement difference.
- Shifts use `B_in[4:0]` only. SRA replicates `A_in[31]`.
- SLT and SLTU return 32-bit 0 or 1, signed and unsigned compare respectively.
- Branch ops:
  - Compare A_in vs B_in, with BLT/BGE signed and BLTU/BGEU unsigned.
  - `Branch_Enable_1` = comparison result; `ALUOut_1` = 0.
- For non-ADD/SUB ops:
  - `last_16_bits_result` = 0, `carry_bit` = 0.
  - `B` = `B_in`, so stage two passes `ALUOut_1` through.
- Single-entry pipeline register. State is `out_valid` only: EMPTY (0) or FULL (1).
- Handshake:
  - `in_ready = !out_valid || out_ready` (combinational).
  - Transfer in = `in_valid && in_ready`.
  - Transfer out = `out_valid && out_ready`.
- Transitions:
  - EMPTY, transfer in → FULL with new data.
  - FULL, transfer out and no transfer in → EMPTY.
  - FULL, transfer out and transfer in in the same cycle → stays FULL, data replaced (back-to-back, no bubble).
  - FULL, `out_ready`=0 → hold; all data outputs stable.
- Flush has priority over everything. On the next edge `out_valid` = 0 and any same-cycle input is dropped. Data registers may hold stale values.
- Data registers load only on transfer in. They are don't-care while `out_valid`=0, but are cleared on reset.

## Timing
- Reset (async assert, sync-safe release): all outputs registered to 0 (`out_valid`, `A`, `B`, `ALUOut_1`, `Branch_Enable_1`, `addition_flag`, `last_16_bits_result`, `carry_bit`). With `out_valid`=0, `in_ready` = 1.
- Reset mid-operation: a held result is lost. There is no output on the cycle after deassertion.
- Latency: 1 cycle. Data accepted at edge N is valid at `out_valid` after edge N.
- Throughput: 1 op/cycle when `out_ready` is held high.
- `in_ready` depends combinationally on `out_ready`. No combinational path from `in_valid` or data to any output.
- Critical path is the 16-bit add plus the 32-bit barrel shift.

## Test plan
- Reset: assert `reset` with `out_valid`=1 holding data → all outputs 0 immediately, `in_ready`=1.
- ADD with carry: A=0x0001FFFF, B=0x00000001 → next cycle `last_16_bits_result`=0x0000, `carry_bit`=1, `addition_flag`=1, `B`=0x00000001. Stage two yields 0x00020000.
- SUB: A=5, B=7 → `B`=0xFFFFFFF8, low=0xFFFE, carry=0. Full result 0xFFFFFFFE. Also A=0x80000000, B=1 → low=0xFFFF, carry=0, full result 0x7FFFFFFF.
- Logic/shift/branch:
  - SRA with A=0x80000000, B=4 → `ALUOut_1`=0xF8000000, `addition_flag`=0.
  - BLT with A=0xFFFFFFFF, B=1 → `Branch_Enable_1`=1.
  - BLTU with the same operands → `Branch_Enable_1`=0.
- Backpressure: issue 3 back-to-back ops with `out_ready`=0 after the first → `in_ready`=0, the first result is held stable. Raising `out_ready` drains all 3 in order, 1 per cycle, with no loss or duplication.
- Flush: FULL with `out_ready`=0, assert `flush` with `in_valid`=1 → next cycle `out_valid`=0 and the input is dropped. The following cycle a new op is accepted normally.
